decode_rom_seq: RTL and testbench
=================================

DECODE_ROM_SEQ -- requirements
Module: decode_rom_seq

Interface
REQ-001 Parameter OPW, default 4, opcode width in bits.
REQ-002 Parameter FLAGW, default 2, flag width in bits (bit 1 = C, bit 0 = Z).
REQ-003 Parameter CW, default 13, control-word width in bits.
REQ-004 Parameter FETCH_WORD, default 13'b1000000001000, control word driven in the fetch phase.
REQ-005 Parameter INIT_FILE, default "", binary table image for execute-phase entries.
REQ-006 Local AW = OPW+FLAGW, execute-table address width; depth 2^AW.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 en  input  1  advance enable; when low, all state holds.
REQ-010 sync  input  1  forces the next phase to fetch.
REQ-011 opcode  input  OPW  instruction opcode.
REQ-012 flags  input  FLAGW  ALU flags {C,Z}.
REQ-013 phase  output  1  current phase: 0 = fetch, 1 = execute.
REQ-014 ctrl  output  CW  registered control word.
REQ-015 ctrl_valid  output  1  high when ctrl holds a word produced since reset.
REQ-016 wr_en, wr_addr[AW-1:0], wr_data[CW-1:0]  inputs  table write port; present only with DECODE_WRITE_EN.

Function
REQ-017 Phase state machine, two states: FETCH(0), EXECUTE(1).
REQ-018 en=1, sync=0: FETCH->EXECUTE, EXECUTE->FETCH on each clock.
REQ-019 en=1, sync=1: next phase = FETCH regardless of current phase.
REQ-020 en=0: phase, ctrl and ctrl_valid hold; sync is ignored.
REQ-021 Lookup address = {opcode, flags}, sampled with the current phase.
REQ-022 Current phase FETCH: ctrl <= FETCH_WORD on the clock, independent of opcode, flags and table.
REQ-023 Current phase EXECUTE: ctrl <= table[{opcode,flags}] on the clock.
REQ-024 Latency: ctrl reflects the phase/opcode/flags sampled at the previous enabled edge (1 cycle).
REQ-025 ctrl_valid <= 1 on the first enabled edge after reset; stays 1 until reset.
REQ-026 Table entries not set by INIT_FILE or a write read as all-zero.
REQ-027 sync during EXECUTE still produces the EXECUTE lookup on that edge; only the next phase changes.

Reset
REQ-028 reset=1 on a clock edge: phase <= 0, ctrl <= 0, ctrl_valid <= 0; reset overrides en, sync and wr_en.
REQ-029 Reset does not alter table contents.
REQ-030 Reset mid-sequence: the first enabled edge after reset release performs a FETCH lookup.

Configuration
REQ-031 Macro DECODE_WRITE_EN compiles in the write port and a writable table.
REQ-032 With DECODE_WRITE_EN: wr_en=1 and reset=0 writes wr_data to table[wr_addr] at the clock edge, independent of en.
REQ-033 With DECODE_WRITE_EN: a same-edge write and EXECUTE lookup to the same address returns the old entry; the new entry is visible from the next edge.
REQ-034 Without DECODE_WRITE_EN: wr_* ports are absent; the table is read-only after INIT_FILE load.

Verification
REQ-035 Reset, then en=1 for 4 cycles, opcode=4'b0010, flags=2'b00, table[8]=13'h0A5 -> ctrl = 13'b1000000001000, 13'h0A5, 13'b1000000001000, 13'h0A5; phase = 1,0,1,0; ctrl_valid = 1 from the first edge.
REQ-036 Flag selection: opcode=4'b1000, EXECUTE, flags=2'b10 vs 2'b01, table[34]=13'h111, table[33]=13'h222 -> ctrl = 13'h111 and 13'h222 respectively.
REQ-037 en=0 for 3 cycles mid-sequence -> phase, ctrl and ctrl_valid unchanged; sequence resumes with no skipped phase.
REQ-038 sync=1 while phase=1 -> next phase=0; sync=1 while phase=0 -> phase stays 0 and ctrl=FETCH_WORD on the following edge.
REQ-039 reset=1 during EXECUTE with en=1 and wr_en=1 -> phase=0, ctrl=0, ctrl_valid=0, no table write.
REQ-040 DECODE_WRITE_EN: write table[5]=13'h1FF on the same edge as an EXECUTE read of address 5 (old value 13'h003) -> ctrl=13'h003; the next EXECUTE read of address 5 -> ctrl=13'h1FF.

Source files
------------

// File: rtl/decode_rom_seq.sv
// ---------------------------------------------------------------------------
// decode_rom_seq
//   Two-phase (fetch / execute) microcode sequencer. In FETCH the registered
//   control word is the constant FETCH_WORD. In EXECUTE it is looked up from a
//   2^(OPW+FLAGW)-entry table addressed by {opcode, flags}. Output is
//   registered, so ctrl reflects the inputs sampled at the previous enabled
//   edge.
//
//   Optional feature: define DECODE_WRITE_EN to compile in a table write port
//   (wr_en / wr_addr / wr_data). Entries not written read as zero.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset (phase, ctrl, ctrl_valid)
//   en         in   advance enable; low holds all sequencer state
//   sync       in   force next phase to FETCH
//   opcode     in   [OPW-1:0]   instruction opcode
//   flags      in   [FLAGW-1:0] ALU flags {C,Z}
//   phase      out  0 = fetch, 1 = execute
//   ctrl       out  [CW-1:0]    registered control word
//   ctrl_valid out  ctrl holds a word produced since reset
//   wr_en      in   table write strobe            (DECODE_WRITE_EN only)
//   wr_addr    in   [AW-1:0] table write address  (DECODE_WRITE_EN only)
//   wr_data    in   [CW-1:0] table write data     (DECODE_WRITE_EN only)
// ---------------------------------------------------------------------------
module decode_rom_seq #(
    parameter int              OPW        = 4,
    parameter int              FLAGW      = 2,
    parameter int              CW         = 13,
    parameter logic [CW-1:0]   FETCH_WORD = 13'b1000000001000,
    parameter string           INIT_FILE  = "",
    localparam int             AW         = OPW + FLAGW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic [OPW-1:0]    opcode,
    input  logic [FLAGW-1:0]  flags,
`ifdef DECODE_WRITE_EN
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CW-1:0]     wr_data,
`endif
    output logic              phase,
    output logic [CW-1:0]     ctrl,
    output logic              ctrl_valid
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [CW-1:0]   ctrl_q, ctrl_d;
    logic            vld_q, vld_d;

    logic [CW-1:0]   table_q [0:DEPTH-1];
    logic [CW-1:0]   rd_word;

    // Memory image: clear everything so uncovered entries read as zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) table_q[i] = '0;
    end

`ifdef DECODE_WRITE_EN
    // Write is independent of en but suppressed by reset. The lookup below is
    // an asynchronous read of the pre-edge contents, so a same-edge write and
    // read of one address returns the old entry.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) table_q[wr_addr] <= wr_data;
    end
`endif

    assign rd_word = table_q[{opcode, flags}];

    always_comb begin
        phase_d = phase_q;
        ctrl_d  = ctrl_q;
        vld_d   = vld_q;
        if (en) begin
            // Lookup uses the current phase; sync only redirects the next one.
            ctrl_d  = (phase_q == FETCH) ? FETCH_WORD : rd_word;
            vld_d   = 1'b1;
            if (sync)                 phase_d = FETCH;
            else if (phase_q == FETCH) phase_d = EXEC;
            else                       phase_d = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= FETCH;
            ctrl_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ctrl_q  <= ctrl_d;
            vld_q   <= vld_d;
        end
    end

    assign phase      = phase_q;
    assign ctrl       = ctrl_q;
    assign ctrl_valid = vld_q;

endmodule

// File: tb/tb_decode_rom_seq.sv
module tb_decode_rom_seq;

    localparam logic [12:0] FW = 13'b1000000001000;

    logic        clk = 1'b0;
    logic        reset, en, sync;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [12:0] wr_data;
    logic        phase;
    logic [12:0] ctrl;
    logic        ctrl_valid;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [12:0] mtab [0:63];
    logic        m_phase;
    logic [12:0] m_ctrl;
    logic        m_valid;

    always #5 clk = ~clk;

    decode_rom_seq dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sync       (sync),
        .opcode     (opcode),
        .flags      (flags),
`ifdef DECODE_WRITE_EN
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`endif
        .phase      (phase),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid)
    );

    // Drive inputs (at negedge), take one rising edge, update the model from
    // the rules, and return at the next negedge for sampling.
    task automatic tick(input logic r, input logic e, input logic s,
                        input logic [3:0] op, input logic [1:0] fl,
                        input logic we, input logic [5:0] wa, input logic [12:0] wd);
        reset = r; en = e; sync = s; opcode = op; flags = fl;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        if (r) begin
            m_phase = 1'b0; m_ctrl = '0; m_valid = 1'b0;
        end else begin
            if (e) begin
                m_ctrl  = m_phase ? mtab[{op, fl}] : FW;
                m_phase = s ? 1'b0 : !m_phase;
                m_valid = 1'b1;
            end
`ifdef DECODE_WRITE_EN
            if (we) mtab[wa] = wd;
`endif
        end
        @(negedge clk);
    endtask

    task automatic load_entry(input logic [5:0] a, input logic [12:0] d);
`ifdef DECODE_WRITE_EN
        tick(1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 1'b1, a, d);
        wr_en = 1'b0;
`else
        dut.table_q[a] = d;
        mtab[a] = d;
`endif
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b1, 1'b0, 4'h3, 2'h1, 1'b0, 6'h0, 13'h0);
        vectors++; if (phase !== 1'b0) begin miscompares++; $display("FAIL reset_phase got %b exp 0", phase); end
        vectors++; if (ctrl !== 13'h0) begin miscompares++; $display("FAIL reset_ctrl got %h exp 0", ctrl); end
        vectors++; if (ctrl_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", ctrl_valid); end
    endtask

    task automatic test_basic;
        logic [12:0] ec [4];
        logic        ep [4];
        ec = '{FW, 13'h0A5, FW, 13'h0A5};
        ep = '{1'b1, 1'b0, 1'b1, 1'b0};
        load_entry(6'd8, 13'h0A5);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 2'h0, 1'b0, 6'h0, 13'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);
            vectors++; if (ctrl !== ec[i]) begin miscompares++; $display("FAIL basic_ctrl[%0d] got %h exp %h", i, ctrl, ec[i]); end
            vectors++; if (phase !== ep[i]) begin miscompares++; $display("FAIL basic_phase[%0d] got %b exp %b", i, phase, ep[i]); end
            vectors++; if (ctrl_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid[%0d] got %b exp 1", i, ctrl_valid); end
        end
    endtask

    task automatic test_flags;
        load_entry(6'd34, 13'h111);
        load_entry(6'd33, 13'h222);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 2'h0, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b1000, 2'b10, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b1000, 2'b10, 1'b0, 6'h0, 13'h0);
        vectors++; if (ctrl !== 13'h111) begin miscompares++; $display("FAIL flags_C got %h exp 111", ctrl); end
        tick(1'b0, 1'b1, 1'b0, 4'b1000, 2'b01, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b1000, 2'b01, 1'b0, 6'h0, 13'h0);
        vectors++; if (ctrl !== 13'h222) begin miscompares++; $display("FAIL flags_Z got %h exp 222", ctrl); end
    endtask

    task automatic test_hold;
        tick(1'b1, 1'b0, 1'b0, 4'h0, 2'h0, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);   // now phase 1, ctrl FW
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, i[0], $urandom_range(0, 15), $urandom_range(0, 3), 1'b0, 6'h0, 13'h0);
            vectors++; if (phase !== 1'b1 || ctrl !== FW || ctrl_valid !== 1'b1) begin
                miscompares++; $display("FAIL hold[%0d] got ph=%b ctrl=%h v=%b exp ph=1 ctrl=%h v=1", i, phase, ctrl, ctrl_valid, FW);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);
        vectors++; if (phase !== 1'b0 || ctrl !== 13'h0A5) begin
            miscompares++; $display("FAIL hold_resume got ph=%b ctrl=%h exp ph=0 ctrl=0a5", phase, ctrl);
        end
    endtask

    task automatic test_sync;
        tick(1'b1, 1'b0, 1'b0, 4'h0, 2'h0, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);   // phase 1
        tick(1'b0, 1'b1, 1'b1, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);   // execute lookup, back to fetch
        vectors++; if (phase !== 1'b0 || ctrl !== 13'h0A5) begin
            miscompares++; $display("FAIL sync_exec got ph=%b ctrl=%h exp ph=0 ctrl=0a5", phase, ctrl);
        end
        tick(1'b0, 1'b1, 1'b1, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);   // sync in fetch
        vectors++; if (phase !== 1'b0 || ctrl !== FW) begin
            miscompares++; $display("FAIL sync_fetch got ph=%b ctrl=%h exp ph=0 ctrl=%h", phase, ctrl, FW);
        end
        tick(1'b0, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);
        vectors++; if (phase !== 1'b1 || ctrl !== FW) begin
            miscompares++; $display("FAIL sync_after got ph=%b ctrl=%h exp ph=1 ctrl=%h", phase, ctrl, FW);
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b0, 1'b1, 1'b1, 4'h0, 2'h0, 1'b0, 6'h0, 13'h0);       // force fetch
        tick(1'b0, 1'b1, 1'b0, 4'h0, 2'h0, 1'b0, 6'h0, 13'h0);       // phase 1
        tick(1'b1, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b1, 6'd8, 13'h1F0);
        vectors++; if (phase !== 1'b0 || ctrl !== 13'h0 || ctrl_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid got ph=%b ctrl=%h v=%b exp 0/0/0", phase, ctrl, ctrl_valid);
        end
        tick(1'b0, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);
        vectors++; if (phase !== 1'b1 || ctrl !== FW || ctrl_valid !== 1'b1) begin
            miscompares++; $display("FAIL rst_first got ph=%b ctrl=%h v=%b exp 1/%h/1", phase, ctrl, ctrl_valid, FW);
        end
        tick(1'b0, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 6'h0, 13'h0);
        vectors++; if (ctrl !== 13'h0A5) begin miscompares++; $display("FAIL rst_nowrite got %h exp 0a5", ctrl); end
    endtask

`ifdef DECODE_WRITE_EN
    task automatic test_write;
        load_entry(6'd5, 13'h003);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 2'h0, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b0001, 2'b01, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b0001, 2'b01, 1'b1, 6'd5, 13'h1FF);
        vectors++; if (ctrl !== 13'h003) begin miscompares++; $display("FAIL wr_old got %h exp 003", ctrl); end
        tick(1'b0, 1'b1, 1'b0, 4'b0001, 2'b01, 1'b0, 6'h0, 13'h0);
        tick(1'b0, 1'b1, 1'b0, 4'b0001, 2'b01, 1'b0, 6'h0, 13'h0);
        vectors++; if (ctrl !== 13'h1FF) begin miscompares++; $display("FAIL wr_new got %h exp 1ff", ctrl); end
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 40; i++) load_entry(6'($urandom_range(0, 63)), 13'($urandom));
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                 4'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), 6'($urandom), 13'($urandom));
            vectors++; if (phase !== m_phase || ctrl !== m_ctrl || ctrl_valid !== m_valid) begin
                miscompares++;
                $display("FAIL rand[%0d] got ph=%b ctrl=%h v=%b exp ph=%b ctrl=%h v=%b",
                         i, phase, ctrl, ctrl_valid, m_phase, m_ctrl, m_valid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mtab[i] = '0;
        m_phase = 1'b0; m_ctrl = '0; m_valid = 1'b0;
        reset = 1'b1; en = 1'b0; sync = 1'b0; opcode = '0; flags = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_flags;
        test_hold;
        test_sync;
        test_reset_mid;
`ifdef DECODE_WRITE_EN
        test_write;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
